pwm_pattern_sequencer: RTL and testbench

Controller that sequences a 6-bit-period PWM generator through a duty-cycle pattern, one duty step per PWM period. It owns the period counter, the pattern step index and the duty register, and serialises mode changes from a host so that duty updates land only on period boundaries. It sits between the switch/host control logic and the LED/PWM output pin, in place of a free-running duty-cycle block.

---
 rtl/pwm_pattern_sequencer.sv | 114 +++++++++++
 tb/tb_pwm_pattern_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pwm_pattern_sequencer.sv
// PWM pattern sequencer: period counter, pattern step index and duty register, with mode changes landing on period boundaries.
// Optional feature: define PWM_SEQ_TRIANGLE_EN to build the triangle shape (otherwise mode 10 behaves as square).
module pwm_pattern_sequencer #(
  parameter int CNT_W  = 6,
  parameter int STEP_W = 6   // must equal CNT_W
) (
  input  logic           sysclk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           mode_valid,
  input  logic [1:0]     mode_sel,
  output logic           mode_ready,
  output logic [CNT_W:0] duty,
  output logic           period_start,
  output logic           pulse,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W:0]    DUTY_FULL = {1'b1, {CNT_W{1'b0}}};
  localparam logic [STEP_W-1:0] STEP_ZERO = '0;
  localparam logic [1:0]        M_SQUARE  = 2'b00;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    count;
  logic [STEP_W-1:0]   index, step_nx;
  logic [1:0]          mode, pend_mode, new_mode, mode_eff;
  logic                pend_vld, period_end, accept, apply;

  function automatic logic [CNT_W:0] shape(input logic [1:0] m, input logic [STEP_W-1:0] idx);
    logic [CNT_W:0] v;
    v = '0;
    case (m)
      2'b01: v = {1'b0, idx};
      2'b11: v = DUTY_FULL;
`ifdef PWM_SEQ_TRIANGLE_EN
      2'b10: v = idx[STEP_W-1] ? {1'b0, ~idx[STEP_W-2:0], 1'b0} : {1'b0, idx[STEP_W-2:0], 1'b0};
`endif
      default: v = idx[STEP_W-1] ? '0 : DUTY_FULL;
    endcase
    return v;
  endfunction

  assign period_end = (state != IDLE) && (count == CNT_MAX);
  assign mode_ready = !pend_vld;
  assign accept     = mode_valid && mode_ready;
  // A pending mode and a fresh acceptance are exclusive, since ready drops while pending.
  assign new_mode   = pend_vld ? pend_mode : mode_sel;
  assign apply      = (pend_vld || accept) && ((state == IDLE) || period_end);
  assign mode_eff   = apply ? new_mode : mode;
  assign step_nx    = apply ? STEP_ZERO : index + 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = DRAIN;
      DRAIN: begin
        if (enable)          state_nx = RUN;
        else if (period_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      count     <= '0;
      index     <= '0;
      duty      <= '0;
      mode      <= M_SQUARE;
      pend_vld  <= 1'b0;
      pend_mode <= M_SQUARE;
    end else begin
      if (apply) begin
        mode     <= new_mode;
        pend_vld <= 1'b0;
      end else if (accept) begin
        pend_vld  <= 1'b1;
        pend_mode <= mode_sel;
      end

      if (state == IDLE) begin
        count <= '0;
        index <= '0;
        duty  <= (state_nx == RUN) ? shape(mode_eff, STEP_ZERO) : '0;
      end else begin
        count <= count + 1'b1;
        // Re-enable during drain continues the pattern as if never stopped.
        if (period_end) begin
          if (state_nx == IDLE) begin
            index <= '0;
            duty  <= '0;
          end else begin
            index <= step_nx;
            duty  <= shape(mode_eff, step_nx);
          end
        end
      end
    end
  end

  assign busy         = (state != IDLE);
  assign period_start = busy && (count == '0);
  assign pulse        = busy && ({1'b0, count} < duty);

endmodule

// File: tb/tb_pwm_pattern_sequencer.sv
// Randomized bench for pwm_pattern_sequencer against a cycle-level behavioural model of the pattern rules.
module tb_pwm_pattern_sequencer;
  localparam int CW   = 6;
  localparam int P    = 1 << CW;
  localparam int NCYC = 22000;

  logic          sysclk = 1'b0;
  logic          rst_n, enable, mode_valid;
  logic [1:0]    mode_sel;
  logic          mode_ready, period_start, pulse, busy;
  logic [CW:0]   duty;

  int total = 0;
  int bad   = 0;

  // model: running flag, stopping flag, phase in period, pattern step, duty, mode, pending modes
  bit m_act, m_stop;
  int m_ph, m_st, m_dt, m_md;
  int m_pend[$];

  pwm_pattern_sequencer #(.CNT_W(CW), .STEP_W(CW)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .mode_valid(mode_valid),
    .mode_sel(mode_sel), .mode_ready(mode_ready), .duty(duty),
    .period_start(period_start), .pulse(pulse), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int shape(input int m, input int i);
    case (m)
      1: return i;
      3: return P;
`ifdef PWM_SEQ_TRIANGLE_EN
      2: return (i < P/2) ? 2*i : 2*(P-1-i);
`endif
      default: return (i < P/2) ? P : 0;
    endcase
  endfunction

  task automatic model_step(input bit rn, input bit en, input bit mv, input int ms);
    bit acc;
    if (!rn) begin
      m_act = 0; m_stop = 0; m_ph = 0; m_st = 0; m_dt = 0; m_md = 0;
      m_pend.delete();
    end else begin
      acc = mv && (m_pend.size() == 0);
      if (!m_act) begin
        if (acc) m_md = ms;
        if (en) begin
          m_act = 1; m_stop = 0; m_ph = 0; m_st = 0;
          m_dt = shape(m_md, 0);
        end
      end else begin
        if (acc) m_pend.push_back(ms);
        if (m_ph == P-1) begin
          if (m_stop && !en) begin
            m_act = 0; m_stop = 0; m_ph = 0; m_st = 0; m_dt = 0;
            if (m_pend.size() != 0) m_md = m_pend.pop_front();
          end else begin
            if (m_pend.size() != 0) begin
              m_md = m_pend.pop_front();
              m_st = 0;
            end else begin
              m_st = (m_st + 1) % P;
            end
            m_dt   = shape(m_md, m_st);
            m_ph   = 0;
            m_stop = !en;
          end
        end else begin
          m_ph++;
          m_stop = !en;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("duty",   int'(duty),         m_dt);
    chk("pulse",  int'(pulse),        int'(m_act && (m_ph < m_dt)));
    chk("pstart", int'(period_start), int'(m_act && (m_ph == 0)));
    chk("busy",   int'(busy),         int'(m_act));
    chk("ready",  int'(mode_ready),   int'(m_pend.size() == 0));
  endtask

  initial begin
    bit rn, en, mv;
    int ms;
    en = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rn = 1; mv = 0; ms = $urandom_range(0, 3);
      if (cyc < 3)              rn = 0;
      else if (cyc == 3)        begin mv = 1; ms = 2; end
      else if (cyc == 5)        en = 1;
      else if (cyc == 4300)     begin mv = 1; ms = 1; end
      else if (cyc == 8600)     en = 0;
      else if (cyc == 8700)     begin mv = 1; ms = 0; end
      else if (cyc == 8702)     en = 1;
      else if (cyc >= 12900) begin
        if ($urandom_range(0, 149) == 0) en = !en;
        mv = ($urandom_range(0, 29) == 0);
        if (m_act && m_ph == P-1 && $urandom_range(0, 3) == 0) mv = 1;
        if ($urandom_range(0, 2999) == 0) rn = 0;
      end
      rst_n = rn; enable = en; mode_valid = mv; mode_sel = 2'(ms);
      model_step(rn, en, mv, ms);
      @(negedge sysclk);
      check_outputs();
      // spot checks of the triangle/square duty at known step indices, first triangle run
      if (cyc < 4300 && m_act && m_ph == 0 && m_md == 2) begin
`ifdef PWM_SEQ_TRIANGLE_EN
        if (m_st == 5)  chk("tri_idx5",  int'(duty), 10);
        if (m_st == 37) chk("tri_idx37", int'(duty), 52);
`else
        if (m_st == 5)  chk("tri_idx5",  int'(duty), 64);
        if (m_st == 37) chk("tri_idx37", int'(duty), 0);
`endif
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
